// File: rtl/gpio_in_pkg.sv
// Shared widths and default timing for the GPIO input conditioner.
// The switch/key bit order here defines the packed gpio_in layout.
package gpio_in_pkg;

    localparam int SW_W   = 18;
    localparam int KEY_W  = 4;
    localparam int GPIO_W = 32;
    localparam int DB_W   = SW_W + KEY_W;
    localparam int CNT_W  = 4;

    localparam int TICK_CYCLES_DEF  = 50000;
    localparam int STABLE_TICKS_DEF = 8;

    // Debounced levels while in reset: switches off, keys released (active-low).
    localparam logic [DB_W-1:0] DB_RESET = {{KEY_W{1'b1}}, {SW_W{1'b0}}};

endpackage

// File: rtl/debounce_bit.sv
// One conditioned input bit: 2-flop synchronizer, then a tick-driven
// mismatch counter that accepts a new level only after STABLE_TICKS ticks.
module debounce_bit
    import gpio_in_pkg::*;
#(
    parameter int   STABLE_TICKS = STABLE_TICKS_DEF,
    parameter logic RESET_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic db
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_TICKS - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;
    logic             synced;

    assign synced = sync_q[1];

    // Any bounce back to the accepted level on a tick restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RESET_VAL}};
            cnt    <= '0;
            db     <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (tick) begin
                if (synced == db) begin
                    cnt <= '0;
                end else if (cnt >= CNT_MAX) begin
                    db  <= synced;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpio_input_conditioner.sv
// Debounces the board switches and keys onto a shared sample tick and
// packs them for the CPU, with per-key press strobes and sticky event flags.
module gpio_input_conditioner
    import gpio_in_pkg::*;
#(
    parameter int TICK_CYCLES  = TICK_CYCLES_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SW_W-1:0]   sw,
    input  logic [KEY_W-1:0]  key,
    output logic [GPIO_W-1:0] gpio_in,
    output logic [KEY_W-1:0]  key_press,
    output logic [KEY_W-1:0]  key_event,
    input  logic [KEY_W-1:0]  event_clr,
    output logic              changed
);

    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_CYCLES - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [DB_W-1:0]  raw;
    logic [DB_W-1:0]  db;
    logic [DB_W-1:0]  db_prev;
    logic [SW_W-1:0]  sw_db;
    logic [KEY_W-1:0] key_db;
    logic [KEY_W-1:0] key_db_prev;

    assign tick        = (pre_cnt == PRE_MAX);
    assign raw         = {key, sw};
    assign sw_db       = db[SW_W-1:0];
    assign key_db      = db[DB_W-1:SW_W];
    assign key_db_prev = db_prev[DB_W-1:SW_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < DB_W; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_VAL    (DB_RESET[i])
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .raw   (raw[i]),
            .db    (db[i])
        );
    end

    // key_press and changed are single-cycle strobes with no back-pressure;
    // db_prev resets to the db reset levels so reset release never strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_prev   <= DB_RESET;
            gpio_in   <= '0;
            key_press <= '0;
            key_event <= '0;
            changed   <= 1'b0;
        end else begin
            db_prev   <= db;
            gpio_in   <= {{(GPIO_W - DB_W){1'b0}}, ~key_db, sw_db};
            key_press <= key_db_prev & ~key_db;
            key_event <= (key_event & ~event_clr) | key_press;
            changed   <= |(db ^ db_prev);
        end
    end

endmodule

// File: doc/gpio_input_conditioner.md
GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000, meaning clk cycles per sample tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter STABLE_TICKS, default 8, meaning consecutive mismatching ticks needed to accept a new level; legal range is 2..15.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock (50 MHz board clock).
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port sw, input, 18 bits: raw asynchronous slide switches.
REQ-006 SHALL have port key, input, 4 bits: raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-007 SHALL have port gpio_in, output, 32 bits: {10'd0, key_down[3:0], sw_db[17:0]}, which feeds the CPU gpio_in.
REQ-008 SHALL have port key_press, output, 4 bits: one-cycle pulse per key on its debounced press.
REQ-009 SHALL have port key_event, output, 4 bits: sticky press flag per key.
REQ-010 SHALL have port event_clr, input, 4 bits: per-key clear of key_event.
REQ-011 SHALL have port changed, output, 1 bit: one-cycle pulse when any debounced bit changes.

Function
REQ-012 SHALL pass every raw input bit through a 2-flop synchronizer before any other use.
REQ-013 SHALL run one shared prescaler counting 0..TICK_CYCLES-1, with tick asserted for one cycle when the count equals TICK_CYCLES-1, then wrapping to 0.
REQ-014 SHALL give each of the 22 bits a state register db and a 4-bit counter cnt, updated only on tick, as follows:
- synced == db: cnt <= 0.
- synced != db and cnt < STABLE_TICKS-1: cnt <= cnt+1.
- synced != db and cnt == STABLE_TICKS-1: db <= synced and cnt <= 0.
REQ-015 SHALL reset cnt to 0 whenever a bit bounces back to its db value on a tick, so a new level is accepted only after STABLE_TICKS consecutive mismatching ticks.
REQ-016 SHALL bound latency from a stable raw change to the db update at 2 sync cycles plus STABLE_TICKS ticks, minus at most TICK_CYCLES-1 cycles of tick phase.
REQ-017 SHALL drive key_down[i] = ~key_db[i], so that gpio_in reports a pressed key as 1.
REQ-018 SHALL pulse key_press[i] for exactly the one clk cycle after key_db[i] goes 1->0; release (0->1) SHALL produce no pulse.
REQ-019 SHALL set key_event[i] on a key_press[i] pulse and clear it on event_clr[i]; when both occur in the same cycle, set wins.
REQ-020 SHALL pulse changed for one cycle after any db bit (switch or key) updates; several bits updating on the same tick SHALL produce a single pulse.
REQ-021 SHALL register all outputs, with no combinational path from any raw input to any output.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force sync flops and db to the released/off values: sw to 0, key to 1.
REQ-023 SHALL, while rst_n=0, asynchronously force cnt, the prescaler, key_press, key_event and changed to 0, giving gpio_in = 32'h0.
REQ-024 SHALL generate no key_press or changed pulse on reset release, even if a key is held; a held key is accepted after STABLE_TICKS ticks and then pulses normally.
REQ-025 SHALL, on reset asserted mid-debounce, discard the partial count with no output glitch.

Structure
REQ-026 SHALL take from package gpio_in_pkg: the constants SW_W=18 and KEY_W=4, the GPIO_W=32 constant, and the default TICK_CYCLES and STABLE_TICKS values.
REQ-027 SHALL use one sub-module, debounce_bit, which holds the synchronizer, cnt and db for one bit and is instantiated 22 times with a shared tick input.
REQ-028 SHALL place the prescaler, edge detect, event flags and gpio_in packing in the top of gpio_input_conditioner.

Verification (bench uses TICK_CYCLES=4, STABLE_TICKS=3)
REQ-029 SHALL cover reset: hold rst_n=0 with key=4'hE and sw=18'h3FFFF, then release -> gpio_in=0 and no pulses until 3 ticks, after which gpio_in=32'h0007FFFF, key_press=4'h1 and changed=1, one cycle each.
REQ-030 SHALL cover bounce rejection: toggle sw[0] every tick for 10 ticks, then hold at 0 -> sw_db[0] stays 0 and changed is never asserted.
REQ-031 SHALL cover clean press: key[2] 1->0 held for 5 ticks -> gpio_in[20]=1, key_press=4'h4 for 1 cycle and key_event[2]=1, all within 2+3*4 cycles.
REQ-032 SHALL cover release: key[2] 0->1 -> gpio_in[20]=0, changed pulses, key_press stays 0 and key_event[2] stays 1.
REQ-033 SHALL cover the simultaneous event: event_clr[2]=1 in the same cycle as a new key_press[2] -> key_event[2] remains 1; event_clr[2]=1 alone -> key_event[2]=0 next cycle.
REQ-034 SHALL cover reset mid-debounce: sw[5]=1 held for 2 ticks, then rst_n pulsed low -> sw_db[5]=0 and cnt=0, after which a full 3 ticks are again required.
